// File: rtl/reg_write_arbiter.sv
// Round-robin write controller driving the in/load/clear controls of one shared register.
// Optional per-requester clear requests are enabled with the REG_ARB_CLEAR_EN macro.
module reg_write_arbiter #(
    parameter int unsigned N  = 8,
    parameter int unsigned R  = 4,
    parameter int unsigned IW = $clog2(R)
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [R-1:0]    req,
    input  logic [R*N-1:0]  wdata,
`ifdef REG_ARB_CLEAR_EN
    input  logic [R-1:0]    clr_req,
`endif
    output logic [R-1:0]    ack,
    output logic [N-1:0]    reg_in,
    output logic            reg_load,
    output logic            reg_clear,
    output logic [IW-1:0]   owner,
    output logic            owner_valid
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic [IW-1:0] last;

    logic          win_found_c;
    logic [IW-1:0] win_idx_c;
    logic [N-1:0]  win_data_c;
    int unsigned   cand;

    // Round-robin search starting one past the previous winner
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        win_data_c  = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= R; k++) begin
            cand = (32'(last) + k) % R;
            if (!win_found_c && req[IW'(cand)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IW'(cand);
                win_data_c  = wdata[cand*N +: N];
            end
        end
    end

    logic          clr_found_c;
    logic [IW-1:0] clr_idx_c;

`ifdef REG_ARB_CLEAR_EN
    // Lowest-index clear request wins
    always_comb begin
        clr_found_c = 1'b0;
        clr_idx_c   = '0;
        for (int i = int'(R) - 1; i >= 0; i--) begin
            if (clr_req[IW'(i)]) begin
                clr_found_c = 1'b1;
                clr_idx_c   = IW'(i);
            end
        end
    end
`else
    assign clr_found_c = 1'b0;
    assign clr_idx_c   = '0;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            last        <= IW'(R - 1);
            ack         <= '0;
            reg_in      <= '0;
            reg_load    <= 1'b0;
            reg_clear   <= 1'b1;
            owner       <= '0;
            owner_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // reg_clear still high here only on the first edge after reset
                    if (reg_clear) begin
                        reg_clear <= 1'b0;
                    end else if (clr_found_c) begin
                        state     <= ISSUE;
                        reg_clear <= 1'b1;
                        ack       <= R'(1) << clr_idx_c;
                    end else if (win_found_c) begin
                        state    <= ISSUE;
                        reg_load <= 1'b1;
                        reg_in   <= win_data_c;
                        ack      <= R'(1) << win_idx_c;
                        last     <= win_idx_c;
                    end
                end
                ISSUE: begin
                    state     <= IDLE;
                    ack       <= '0;
                    reg_load  <= 1'b0;
                    reg_clear <= 1'b0;
                    if (reg_clear) begin
                        owner_valid <= 1'b0;
                    end else begin
                        owner       <= last;
                        owner_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural model of the shared register.
module tb_reg_write_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned IW = 2;

    logic            clk;
    logic            clear_n;
    logic [R-1:0]    req;
    logic [R*N-1:0]  wdata;
`ifdef REG_ARB_CLEAR_EN
    logic [R-1:0]    clr_req;
`endif
    logic [R-1:0]    ack;
    logic [N-1:0]    reg_in;
    logic            reg_load;
    logic            reg_clear;
    logic [IW-1:0]   owner;
    logic            owner_valid;

    logic [N-1:0]    reg_out;

    int vectors = 0;
    int errors  = 0;

    reg_write_arbiter #(.N(N), .R(R), .IW(IW)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .req         (req),
        .wdata       (wdata),
`ifdef REG_ARB_CLEAR_EN
        .clr_req     (clr_req),
`endif
        .ack         (ack),
        .reg_in      (reg_in),
        .reg_load    (reg_load),
        .reg_clear   (reg_clear),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared load/clear register fed by the arbiter
    always @(posedge clk) begin
        if (reg_clear)     reg_out <= '0;
        else if (reg_load) reg_out <= reg_in;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        step();
    endtask

    initial begin
        logic [IW-1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        clear_n = 1'b1;
        req     = '0;
        wdata   = '0;
`ifdef REG_ARB_CLEAR_EN
        clr_req = '0;
`endif
        #3;
        // 1: reset, then release with nothing pending
        clear_n = 1'b0;
        #1;
        chk("rst_clear_async", 32'(reg_clear), 32'd1);
        step();
        step();
        chk("rst_clear", 32'(reg_clear), 32'd1);
        chk("rst_load", 32'(reg_load), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_owner_valid", 32'(owner_valid), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_reg_out", 32'(reg_out), 32'd0);
        clear_n = 1'b1;
        step();
        chk("rel_clear", 32'(reg_clear), 32'd0);
        chk("rel_load", 32'(reg_load), 32'd0);
        step();
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_owner_valid", 32'(owner_valid), 32'd0);

        // 2: single requester 2
        req   = 4'b0100;
        wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
        step();
        chk("r2_load", 32'(reg_load), 32'd1);
        chk("r2_ack", 32'(ack), 32'h4);
        chk("r2_reg_in", 32'(reg_in), 32'hA5);
        chk("r2_owner_valid_pre", 32'(owner_valid), 32'd0);
        req   = '0;
        wdata = {8'h00, 8'hFF, 8'h00, 8'h00};
        step();
        chk("r2_load_off", 32'(reg_load), 32'd0);
        chk("r2_ack_off", 32'(ack), 32'd0);
        chk("r2_reg_out", 32'(reg_out), 32'hA5);
        chk("r2_owner", 32'(owner), 32'd2);
        chk("r2_owner_valid", 32'(owner_valid), 32'd1);

        // 3: all requesters continuously, starting from reset priority
        do_reset();
        chk("rr_reg_out_rst", 32'(reg_out), 32'd0);
        req   = 4'b1111;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_ack", 32'(ack), 32'(4'b0001 << order[g]));
            chk("rr_load", 32'(reg_load), 32'd1);
            chk("rr_excl", 32'(reg_load & reg_clear), 32'd0);
            step();
            chk("rr_ack_gap", 32'(ack), 32'd0);
            chk("rr_reg_out", 32'(reg_out), 32'h10 + 32'(order[g]));
            chk("rr_owner", 32'(owner), 32'(order[g]));
        end
        req = '0;
        step();

        // 4: set last=3, then 0 and 3 together wrap to 0 first
        req = 4'b1000;
        step();
        chk("wrap_pre_ack", 32'(ack), 32'h8);
        req = 4'b1001;
        step();
        step();
        chk("wrap_first", 32'(ack), 32'h1);
        chk("wrap_first_data", 32'(reg_in), 32'h10);
        step();
        step();
        chk("wrap_second", 32'(ack), 32'h8);
        chk("wrap_second_data", 32'(reg_in), 32'h13);
        req = '0;
        step();
        chk("wrap_owner", 32'(owner), 32'd3);

        // 5: reset during the ISSUE of requester 1
        req   = 4'b0010;
        wdata = {8'h00, 8'h00, 8'h7E, 8'h33};
        step();
        chk("abort_issue_ack", 32'(ack), 32'h2);
        clear_n = 1'b0;
        req     = 4'b0011;
        #1;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_load", 32'(reg_load), 32'd0);
        chk("abort_clear", 32'(reg_clear), 32'd1);
        chk("abort_owner_valid", 32'(owner_valid), 32'd0);
        step();
        chk("abort_reg_out", 32'(reg_out), 32'd0);
        clear_n = 1'b1;
        step();
        chk("abort_rel_ack", 32'(ack), 32'd0);
        chk("abort_rel_load", 32'(reg_load), 32'd0);
        step();
        chk("abort_next_ack", 32'(ack), 32'h1);
        chk("abort_next_data", 32'(reg_in), 32'h33);
        req = '0;
        step();
        chk("abort_next_reg_out", 32'(reg_out), 32'h33);
        chk("abort_next_owner", 32'(owner), 32'd0);

`ifdef REG_ARB_CLEAR_EN
        // 6: clear request beats a pending write
        clr_req = 4'b1000;
        req     = 4'b0010;
        wdata   = {8'h00, 8'h00, 8'h55, 8'h00};
        step();
        chk("clr_clear", 32'(reg_clear), 32'd1);
        chk("clr_load", 32'(reg_load), 32'd0);
        chk("clr_ack", 32'(ack), 32'h8);
        clr_req = '0;
        step();
        chk("clr_owner_valid", 32'(owner_valid), 32'd0);
        chk("clr_reg_out", 32'(reg_out), 32'd0);
        step();
        chk("clr_w_ack", 32'(ack), 32'h2);
        chk("clr_w_load", 32'(reg_load), 32'd1);
        req = '0;
        step();
        chk("clr_w_reg_out", 32'(reg_out), 32'h55);
        chk("clr_w_owner_valid", 32'(owner_valid), 32'd1);
        chk("clr_w_owner", 32'(owner), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write controller for the shared load/clear register. Up to R requesters each present a data word and a request. The arbiter grants one requester at a time and drives the register's `in`, `load` and `clear` controls. It also tracks which requester last wrote the register. It sits between the requester blocks and a single N-bit register instance, and is the only driver of that register's controls.

## Interface
- `N`, default 8: data width, equal to the register width.
- `R`, default 4: number of requesters, minimum 2.
- `IW`, default `$clog2(R)`: width of the requester index.

Ports (clock and reset first):
- `clk`  in  1  system clock, rising-edge active
- `clear_n`  in  1  reset, asynchronous, active-low
- `req`  in  R  write request per requester, level-sensitive
- `wdata`  in  R*N  requester i's data in bits [i*N +: N]
- `ack`  out  R  one-hot, one-cycle pulse: requester i's write was issued
- `reg_in`  out  N  data to the register's `in`
- `reg_load`  out  1  to the register's `load`
- `reg_clear`  out  1  to the register's `clear` (active-high)
- `owner`  out  IW  index of the last requester whose write was issued
- `owner_valid`  out  1  high once any write has been issued since the last reset or clear
- `clr_req`  in  R  per-requester clear request (present only with `REG_ARB_CLEAR_EN`)

## Operation
- FSM states:
  - IDLE: at a rising edge in IDLE, if any request is pending, pick a winner and go to ISSUE.
  - ISSUE: lasts exactly one cycle, then returns to IDLE unconditionally.
- ISSUE cycle outputs:
  - `reg_load`=1 and `reg_in`=winner's `wdata`, captured at the IDLE→ISSUE edge.
  - `ack[winner]`=1.
  - All outputs are registered. No combinational path from `req` to any output.
- Round-robin:
  - Pointer `last` holds the most recent winner.
  - Search order is `last`+1, `last`+2, …, wrapping modulo R.
  - `last` updates to the winner at the IDLE→ISSUE edge.
- Owner tracking:
  - `owner` takes the winner's index at the ISSUE→IDLE edge.
  - `owner_valid` goes 1 at the same edge.
- Each ack consumes one write. A requester whose `req` is still high when sampled in the following IDLE cycle is treated as a new request and competes normally.
- Changes to `wdata` or `req` during ISSUE have no effect on the write in progress.
- Reset (`clear_n`=0, asynchronous), all take effect immediately:
  - state=IDLE, `last`=R-1 (so requester 0 has priority first).
  - `ack`=0, `reg_load`=0, `reg_in`=0.
  - `owner`=0, `owner_valid`=0.
  - `reg_clear`=1, so the shared register is cleared during reset.
- Reset release: `reg_clear` drops to 0 at the first rising edge after `clear_n` returns to 1. No grant is made at that edge.
- Reset during ISSUE: the write is abandoned, no ack is produced, and the register is cleared.

## Timing
- Request sampled high at edge k (FSM in IDLE) → `reg_load`/`ack` high during cycle k..k+1 → register `out` equals the data after edge k+1.
- Latency from request to register update is 2 edges.
- Throughput is one write per 2 cycles, because ISSUE is always followed by at least one IDLE.
- Simultaneous requests: only one is granted per ISSUE. The rest wait. With all R requesting continuously, each requester is granted within 2R cycles.
- `reg_load` and `reg_clear` are never high in the same cycle.

## Configuration
- `REG_ARB_CLEAR_EN` defined:
  - The `clr_req` port exists.
  - A pending clear takes priority over every pending write.
  - A clear gets its own one-cycle ISSUE with `reg_clear`=1, `reg_load`=0, and `ack` pulsed to the clear's requester (lowest index wins among clears).
  - A clear sets `owner_valid`=0 and does not move `last`.
- Not defined:
  - No `clr_req` port.
  - `reg_clear` is high only during reset.

## Test plan
Bench parameters: N=8, R=4, default configuration.

1. Reset, then release with no requests → `reg_clear`=1 during reset and 0 after the first edge; `reg_load`, `ack` and `owner_valid` stay 0; register `out`=0x00.
2. Only requester 2 raises `req` with `wdata`=0xA5 → `reg_load`=1 and `ack`=4'b0100 in the cycle after sampling; the register holds 0xA5 one edge later; `owner`=2, `owner_valid`=1.
3. All four requesters held high continuously, with data 0x10/0x11/0x12/0x13 → grants in order 0,1,2,3,0 on ISSUE cycles spaced 2 cycles apart; the register sequence is 0x10, 0x11, 0x12, 0x13, 0x10.
4. `last`=3, then requesters 0 and 3 request together → requester 0 is granted first (wrap-around) and requester 3 two cycles later.
5. `clear_n` pulsed low during the ISSUE of requester 1 writing 0x7E → `ack` stays 0, the register reads 0x00, and requester 0 wins the next arbitration.
6. With `REG_ARB_CLEAR_EN`, `clr_req[3]` and `req[1]` (data 0x55) asserted together → the first ISSUE has `reg_clear`=1 and `ack`=4'b1000; the next ISSUE writes 0x55 with `ack`=4'b0010; `owner_valid` is 0 after the clear and 1 after the write.
